// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for decode_queue.
// slave: the queue (accepts in_*, presents out_*); master: fetch + execute.
// Ports: in_valid/in_ready/in_inst/in_pc, out_valid/out_ready/out_pc/out_illegal/out_mdu/out_decode, count.
interface decode_queue_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic [31:0]                  in_inst;
   logic [PC_W-1:0]              in_pc;
   logic                         out_valid;
   logic                         out_ready;
   logic [PC_W-1:0]              out_pc;
   logic                         out_illegal;
   logic                         out_mdu;
   logic [71:0]                  out_decode;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_illegal, out_mdu, out_decode, count
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_illegal, out_mdu, out_decode, count
   );
endinterface

// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry FIFO of decoded control words; decode at enqueue.
// Latency: push in cycle N is visible at the head in N+1 (no in_* -> out_* combinational path).
// Backpressure: in_ready = ~full from registered count (no push while full, even with a pop); flush wins.
// Ports: clk, rst_n (async active-low), flush (sync clear), bus (decode_queue_if.slave).
// Optional feature: define RV_MEXT_EN to decode the M extension (funct7 = 0000001 on OP).
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   decode_queue_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      IT_R   = 3'd0,
      IT_I   = 3'd1,
      IT_S   = 3'd2,
      IT_B   = 3'd3,
      IT_U   = 3'd4,
      IT_J   = 3'd5,
      IT_ILL = 3'd7
   } itype_e;

   // Field order is the out_decode bit layout, MSB first.
   typedef struct packed {
      itype_e      itype;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [5:0]  ext_op;
      logic [2:0]  npc_op;
      logic        alu_src;
      logic [4:0]  alu_op;
      logic        dm_we;
      logic        dm_sign;
      logic [1:0]  dm_width;
      logic        rf_we;
      logic [1:0]  rf_wsrc;
   } decode_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            illegal;
`ifdef RV_MEXT_EN
      logic            mdu;
`endif
      decode_t         dec;
   } entry_t;

   // ------------------------------------------------------------------
   // Decoder (pure function of in_inst)
   // ------------------------------------------------------------------
   logic [31:0] inst;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign inst   = bus.in_inst;
   assign opc    = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_sh = {27'b0, inst[24:20]};

   decode_t dec_d;
   logic    ill_d;
`ifdef RV_MEXT_EN
   logic    mdu_d;
`endif

   always_comb begin
      dec_d          = '0;
      ill_d          = 1'b0;
`ifdef RV_MEXT_EN
      mdu_d          = 1'b0;
`endif
      // Register specifiers and memory size/sign are passed through raw for every type.
      dec_d.rs1      = inst[19:15];
      dec_d.rs2      = inst[24:20];
      dec_d.rd       = inst[11:7];
      dec_d.dm_sign  = f3[2];
      dec_d.dm_width = f3[1:0];

      if (inst[1:0] != 2'b11) begin
         ill_d = 1'b1;
      end else begin
         case (opc)
            OPC_OP: begin
               dec_d.itype = IT_R;
               dec_d.rf_we = 1'b1;
               if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                  dec_d.alu_op = {1'b0, f7[5], f3};
               end
`ifdef RV_MEXT_EN
               else if (f7 == 7'b0000001) begin
                  dec_d.alu_op = {2'b00, f3};
                  mdu_d        = 1'b1;
               end
`endif
               else begin
                  ill_d = 1'b1;
               end
            end
            OPC_OPIMM: begin
               dec_d.itype   = IT_I;
               dec_d.alu_src = 1'b1;
               dec_d.rf_we   = 1'b1;
               if (f3 == 3'b001 || f3 == 3'b101) begin
                  // srai is the only shift allowed a non-zero funct7 (bit 5 selects arithmetic).
                  if (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)) begin
                     dec_d.ext_op = 6'b100000;
                     dec_d.imm    = imm_sh;
                     dec_d.alu_op = {1'b0, f7[5], f3};
                  end else begin
                     ill_d = 1'b1;
                  end
               end else begin
                  dec_d.ext_op = 6'b010000;
                  dec_d.imm    = imm_i;
                  dec_d.alu_op = {2'b00, f3};
               end
            end
            OPC_LOAD: begin
               dec_d.itype   = IT_I;
               dec_d.ext_op  = 6'b010000;
               dec_d.imm     = imm_i;
               dec_d.alu_src = 1'b1;
               dec_d.rf_we   = 1'b1;
               dec_d.rf_wsrc = 2'b01;
               if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill_d = 1'b1;
            end
            OPC_STORE: begin
               dec_d.itype   = IT_S;
               dec_d.ext_op  = 6'b001000;
               dec_d.imm     = imm_s;
               dec_d.alu_src = 1'b1;
               dec_d.dm_we   = 1'b1;
               if (f3[2] || f3 == 3'b011) ill_d = 1'b1;
            end
            OPC_BRANCH: begin
               dec_d.itype  = IT_B;
               dec_d.ext_op = 6'b000100;
               dec_d.imm    = imm_b;
               dec_d.npc_op = 3'b001;
               dec_d.alu_op = {2'b10, f3};
               if (f3 == 3'b010 || f3 == 3'b011) ill_d = 1'b1;
            end
            OPC_JALR: begin
               dec_d.itype   = IT_I;
               dec_d.ext_op  = 6'b010000;
               dec_d.imm     = imm_i;
               dec_d.npc_op  = 3'b100;
               dec_d.alu_src = 1'b1;
               dec_d.rf_we   = 1'b1;
               dec_d.rf_wsrc = 2'b10;
               if (f3 != 3'b000) ill_d = 1'b1;
            end
            OPC_JAL: begin
               dec_d.itype   = IT_J;
               dec_d.ext_op  = 6'b000001;
               dec_d.imm     = imm_j;
               dec_d.npc_op  = 3'b010;
               dec_d.alu_src = 1'b1;
               dec_d.rf_we   = 1'b1;
               dec_d.rf_wsrc = 2'b10;
            end
            OPC_LUI, OPC_AUIPC: begin
               dec_d.itype   = IT_U;
               dec_d.ext_op  = 6'b000010;
               dec_d.imm     = imm_u;
               dec_d.alu_src = 1'b1;
               dec_d.alu_op  = (opc == OPC_LUI) ? 5'b11001 : 5'b11010;
               dec_d.rf_we   = 1'b1;
            end
            // FENCE/SYSTEM are not executed by this pipeline and trap as illegal.
            default: ill_d = 1'b1;
         endcase
      end

      // Illegal entries carry no side effects: only raw register/funct3 fields survive.
      if (ill_d) begin
         dec_d.itype   = IT_ILL;
         dec_d.imm     = '0;
         dec_d.ext_op  = '0;
         dec_d.npc_op  = '0;
         dec_d.alu_src = 1'b0;
         dec_d.alu_op  = '0;
         dec_d.dm_we   = 1'b0;
         dec_d.rf_we   = 1'b0;
         dec_d.rf_wsrc = '0;
`ifdef RV_MEXT_EN
         mdu_d         = 1'b0;
`endif
      end
   end

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   entry_t          mem_q [DEPTH];
   entry_t          entry_d;
   entry_t          head;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full, empty, push, pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.in_valid & ~full & ~flush;
   assign pop   = bus.out_ready & ~empty & ~flush;

   always_comb begin
      entry_d         = '0;
      entry_d.pc      = bus.in_pc;
      entry_d.illegal = ill_d;
`ifdef RV_MEXT_EN
      entry_d.mdu     = mdu_d;
`endif
      entry_d.dec     = dec_d;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q] <= entry_d;
      end
   end

   // Head is read straight from storage; when empty it shows the stale slot.
   assign head            = mem_q[rd_ptr_q];
   assign bus.in_ready    = ~full;
   assign bus.out_valid   = ~empty;
   assign bus.out_pc      = head.pc;
   assign bus.out_illegal = head.illegal;
   assign bus.out_decode  = head.dec;
   assign bus.count       = count_q;
`ifdef RV_MEXT_EN
   assign bus.out_mdu     = head.mdu;
`else
   assign bus.out_mdu     = 1'b0;
`endif

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, handshaked RV32I instruction decoder sitting between the fetch stage and the issue/execute stage. It accepts instruction/PC pairs on a valid/ready interface, decodes them at enqueue time into the team's control-field set (EXTop, NPCop, ALUsrc, ALUop, DM*, RFW*), flags illegal encodings, and holds the decoded entries in a DEPTH-entry FIFO. Entries are presented to execute on a second valid/ready interface. A synchronous flush discards all entries on a redirect.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PC_W, 32: width of the PC carried alongside each instruction.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals ~full; registered.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  head entry valid; equals ~empty.
- out_ready  in  1  execute consumes the head.
- out_pc  out  PC_W  PC of the head entry.
- out_illegal  out  1  head entry is an illegal encoding.
- out_mdu  out  1  head is an M-extension op; always 0 without RV_MEXT_EN.
- out_decode  out  72  {InstType[2:0], rs1[4:0], rs2[4:0], rd[4:0], imm[31:0], EXTop[5:0], NPCop[2:0], ALUsrc, ALUop[4:0], DMWe, DMsign, DMwidth[1:0], RFWe, RFWsrc[1:0]}.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push occurs when in_valid & in_ready and there is no flush; in_inst is decoded combinationally and the result is written at wr_ptr. Pop occurs when out_valid & out_ready.
- Field extraction: rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7]. The fields are raw for every type.
- InstType: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- EXTop (one-hot):
  - 100000: slli/srli/srai; imm = zero-extended shamt.
  - 010000: loads, ALU-immediate ops other than shifts, and jalr; imm = sign-extended inst[31:20].
  - 001000: stores; imm = sign-extended {inst[31:25], inst[11:7]}.
  - 000100: branches; imm = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 000010: lui/auipc; imm = {inst[31:12], 12'b0}.
  - 000001: jal; imm = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type and illegal instructions: EXTop = 0 and imm = 0.
- NPCop: 000 for sequential PC, 001 for branch, 010 for jal, 100 for jalr.
- ALUsrc = 1 for loads, ALU-immediate ops, stores, jal, jalr, lui and auipc.
- ALUop:
  - [2:0] = funct3 for R, ALU-immediate and branch instructions.
  - [3] = funct7[5] for R-type, and 1 for srai.
  - [4] = 1 for branches.
  - lui = 11001 and auipc = 11010.
  - All other instructions give 00000.
  - M-extension ops give {2'b00, funct3} with out_mdu = 1.
- Memory fields: DMWe = 1 for stores. DMsign = funct3[2] and DMwidth = funct3[1:0].
- RFWe = 1 for R, loads, ALU-immediate, jal, jalr, lui and auipc.
- RFWsrc: 00 ALU, 01 memory (loads), 10 PC+4 (jal/jalr).
- Illegal encodings:
  - inst[1:0] != 11, or an opcode outside the RV32I set.
  - R-type with funct7 other than 0000000, or 0100000 with funct3 000/101.
  - Shift-immediate with funct7 other than 0000000 (or 0100000 for funct3 101).
  - Load funct3 of 011, 110 or 111; store funct3 of 1xx or 011; branch funct3 of 010 or 011; jalr funct3 != 000.
  - An illegal entry has InstType = 7, out_illegal = 1, and all of the following zero: EXTop, imm, NPCop, ALUsrc, ALUop, DMWe, RFWe and RFWsrc.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is updated by +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.

## Timing
- Reset (rst_n low, asynchronous) clears pointers, count and all storage. Resulting outputs:
  - out_valid = 0, in_ready = 1, count = 0.
  - out_decode = 0, out_pc = 0, out_illegal = 0, out_mdu = 0.
- Latency: an instruction pushed in cycle N is visible at the outputs from cycle N+1 when the queue was empty. There is no combinational path from in_* to out_*.
- in_ready depends only on registered count. When full, no push is accepted even if a pop occurs in the same cycle.
- Empty: out_valid = 0 and out_decode shows the stale slot; consumers must qualify with out_valid.
- Simultaneous push and pop at 0 < count < DEPTH: count is held and both pointers advance.
- flush has priority over push and pop: in the next cycle count = 0 and the pointers are reset. The in_inst presented in the flush cycle is dropped.
- Handshake: out_* is stable while out_valid & ~out_ready. in_inst/in_pc are sampled only on an accepted push.
- Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.

## Configuration
- RV_MEXT_EN defined: R-type with funct7 = 0000001 decodes as mul/mulh/mulhsu/mulhu/div/divu/rem/remu. These give InstType = 0, RFWe = 1, out_mdu = 1 and ALUop = {00, funct3}.
- RV_MEXT_EN undefined: those encodings are illegal, and out_mdu is tied to 0.

## Test plan
- Reset, then push add x3,x1,x2 (0x002081B3) at PC 0x100. Next cycle: out_valid = 1, InstType = 0, rs1 = 1, rs2 = 2, rd = 3, ALUop = 00000, RFWe = 1, RFWsrc = 00, out_pc = 0x100.
- Push, one per cycle, the following; each head must show the listed fields:
  - addi x5,x0,-1 (0xFFF00293): imm = 0xFFFFFFFF, EXTop = 010000.
  - srai x6,x6,3 (0x40335313): ALUop = 01101, imm = 3.
  - lui x7,0x12345 (0x123453B7): imm = 0x12345000, ALUop = 11001.
  - jal x1,+8 (0x008000EF): imm = 8, NPCop = 010, RFWsrc = 10.
- Push DEPTH entries with out_ready = 0: in_ready falls after the DEPTH-th accept and count = DEPTH. One pop then restores in_ready in the next cycle. Entries drain in FIFO order with correct wrap-around across 2×DEPTH pushes.
- Simultaneous push and pop at count = 2 over 10 cycles: count stays 2 and no entry is lost or duplicated.
- Push 0x00000000 and 0x02208033: the first shows out_illegal = 1, InstType = 7, RFWe = 0. The second shows out_illegal = 1 without RV_MEXT_EN, and out_mdu = 1 with it.
- Fill to 3 entries, then assert flush together with in_valid: the next cycle shows count = 0 and out_valid = 0. Dropping rst_n mid-stream gives out_valid = 0 before the next clock edge.
